// File: rtl/alpha_col_streamer.sv
// Two-bank ping-pong column buffer that plays a committed frame of I columns
// as consecutive beats on the alpha_u_col stream, with tlast on the final beat.
module alpha_col_streamer #(
    parameter int J    = 14,
    parameter int I    = 7,
    parameter int W    = 64,
    parameter int AUTO = 0,
    localparam int AW  = (I > 1) ? $clog2(I) : 1,
    localparam int DW  = J * W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          wr_commit,
    input  logic          start,
    output logic [DW-1:0] alpha_u_col,
    output logic          alpha_u_col_tvalid,
    output logic          alpha_u_col_tlast,
    output logic          busy,
    output logic [1:0]    bank_full,
    output logic          err
);
    typedef enum logic {S_IDLE, S_STREAM} state_t;

    localparam logic [AW:0]   I_L  = (AW + 1)'(I);
    localparam logic [AW-1:0] LAST = AW'(I - 1);

    state_t        r_state;
    logic          r_wb;
    logic          r_rb;
    logic [1:0]    r_bank_full;
    logic [AW-1:0] r_idx;
    logic          r_tvalid;
    logic          r_tlast;
    logic          r_err;
    logic [DW-1:0] r_rd_data;
    logic [DW-1:0] r_mem [2][I];

    logic          w_addr_ok;
    logic          w_wr_ok;
    logic          w_wr_rej;
    logic          w_cm_ok;
    logic          w_cm_rej;
    logic          w_st_ok;
    logic          w_st_rej;
    logic          w_last;
    logic          w_chain;
    logic          w_adv;
    logic          w_emit;
    logic          w_rd_bank;
    logic [AW-1:0] w_rd_idx;
    logic [1:0]    w_bank_full;

    assign w_addr_ok = ({1'b0, wr_addr} < I_L);
    assign w_wr_ok   = wr_en && w_addr_ok && !r_bank_full[r_wb];
    assign w_wr_rej  = wr_en && w_addr_ok && r_bank_full[r_wb];
    assign w_cm_ok   = wr_commit && !r_bank_full[r_wb];
    assign w_cm_rej  = wr_commit && r_bank_full[r_wb];
    assign w_st_ok   = (r_state == S_IDLE) && start && r_bank_full[r_rb];
    assign w_st_rej  = (r_state == S_IDLE) && start && !r_bank_full[r_rb];

    // The tlast beat is on the wire, so this edge releases the bank being played.
    assign w_last    = (r_state == S_STREAM) && (r_idx == LAST);
    assign w_chain   = w_last && (AUTO != 0) && r_bank_full[~r_rb];
    assign w_adv     = (r_state == S_STREAM) && !w_last;
    assign w_emit    = w_st_ok || w_adv || w_chain;
    assign w_rd_bank = w_chain ? ~r_rb : r_rb;
    assign w_rd_idx  = w_adv ? AW'(r_idx + 1'b1) : '0;

    always_comb begin
        w_bank_full = r_bank_full;
        if (w_last) begin
            w_bank_full[r_rb] = 1'b0;
        end
        if (w_cm_ok) begin
            w_bank_full[r_wb] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[r_wb][wr_addr] <= wr_data;
        end
        r_rd_data <= r_mem[w_rd_bank][w_rd_idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_wb        <= 1'b0;
            r_rb        <= 1'b0;
            r_bank_full <= 2'b00;
            r_idx       <= '0;
            r_tvalid    <= 1'b0;
            r_tlast     <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_err       <= w_wr_rej || w_cm_rej || w_st_rej;
            r_bank_full <= w_bank_full;
            if (w_cm_ok) begin
                r_wb <= ~r_wb;
            end
            if (w_last) begin
                r_rb <= ~r_rb;
            end
            r_state  <= w_emit ? S_STREAM : S_IDLE;
            r_idx    <= w_rd_idx;
            r_tvalid <= w_emit;
            r_tlast  <= w_emit && (w_rd_idx == LAST);
        end
    end

    // Data is forced to zero outside a beat, including straight after reset.
    assign alpha_u_col        = r_tvalid ? r_rd_data : '0;
    assign alpha_u_col_tvalid = r_tvalid;
    assign alpha_u_col_tlast  = r_tlast;
    assign busy               = (r_state == S_STREAM);
    assign bank_full          = r_bank_full;
    assign err                = r_err;

endmodule

// File: tb/tb_alpha_col_streamer.sv
// Drives two streamers (AUTO=0 and AUTO=1) with shared stimulus and checks
// every cycle against a frame-level reference model.
module tb_alpha_col_streamer;
    localparam int J  = 14;
    localparam int I  = 7;
    localparam int W  = 64;
    localparam int DW = J * W;
    localparam int AW = $clog2(I);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_commit;
    logic          start;

    logic [DW-1:0] col  [2];
    logic          tv   [2];
    logic          tl   [2];
    logic          bsy  [2];
    logic [1:0]    bf   [2];
    logic          er   [2];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alpha_col_streamer #(.J(J), .I(I), .W(W), .AUTO(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_commit(wr_commit), .start(start),
        .alpha_u_col(col[0]), .alpha_u_col_tvalid(tv[0]),
        .alpha_u_col_tlast(tl[0]), .busy(bsy[0]), .bank_full(bf[0]), .err(er[0])
    );

    alpha_col_streamer #(.J(J), .I(I), .W(W), .AUTO(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_commit(wr_commit), .start(start),
        .alpha_u_col(col[1]), .alpha_u_col_tvalid(tv[1]),
        .alpha_u_col_tlast(tl[1]), .busy(bsy[1]), .bank_full(bf[1]), .err(er[1])
    );

    // Reference model: per instance, bank contents, flags, and a snapshot of
    // the frame(s) being played as a list of expected beats.
    logic [DW-1:0] m_bank [2][2][I];
    logic [1:0]    m_full [2];
    logic          m_wb   [2];
    logic          m_rb   [2];
    logic [DW-1:0] m_fr   [2][I];
    logic          m_fl   [2][I];
    int            m_n    [2];
    int            m_p    [2];
    logic          m_v    [2];
    logic          m_l    [2];
    logic [DW-1:0] m_d    [2];
    logic          m_e    [2];

    task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_full[k] = 2'b00; m_wb[k] = 1'b0; m_rb[k] = 1'b0;
            m_n[k] = 0; m_p[k] = 0;
            m_v[k] = 1'b0; m_l[k] = 1'b0; m_d[k] = '0; m_e[k] = 1'b0;
        end
    endtask

    task automatic load_frame(input int k, input logic b);
        for (int c = 0; c < I; c++) begin
            m_fr[k][c] = m_bank[k][b][c];
            m_fl[k][c] = (c == I - 1);
        end
        m_n[k] = I;
        m_p[k] = 0;
    endtask

    task automatic model_edge(input int k, input bit auto_mode);
        logic [1:0] f;
        bit wr_valid;
        bit rel;
        f        = m_full[k];
        wr_valid = wr_en && (int'(wr_addr) < I);
        rel      = m_v[k] && m_l[k];
        m_e[k]   = (wr_valid && f[m_wb[k]]) || (wr_commit && f[m_wb[k]]) ||
                   (!m_v[k] && start && !f[m_rb[k]]);
        if (wr_valid && !f[m_wb[k]])
            m_bank[k][m_wb[k]][wr_addr] = wr_data;
        if (rel) begin
            m_full[k][m_rb[k]] = 1'b0;
            if (auto_mode && f[!m_rb[k]])
                load_frame(k, !m_rb[k]);
            m_rb[k] = !m_rb[k];
        end else if (!m_v[k] && start && f[m_rb[k]]) begin
            load_frame(k, m_rb[k]);
        end
        if (wr_commit && !f[m_wb[k]]) begin
            m_full[k][m_wb[k]] = 1'b1;
            m_wb[k] = !m_wb[k];
        end
        if (m_p[k] < m_n[k]) begin
            m_d[k] = m_fr[k][m_p[k]];
            m_l[k] = m_fl[k][m_p[k]];
            m_v[k] = 1'b1;
            m_p[k]++;
        end else begin
            m_d[k] = '0; m_l[k] = 1'b0; m_v[k] = 1'b0;
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            check_val($sformatf("tvalid%0d", k), DW'(tv[k]),  DW'(m_v[k]));
            check_val($sformatf("tlast%0d", k),  DW'(tl[k]),  DW'(m_l[k]));
            check_val($sformatf("data%0d", k),   col[k],      m_d[k]);
            check_val($sformatf("busy%0d", k),   DW'(bsy[k]), DW'(m_v[k]));
            check_val($sformatf("full%0d", k),   DW'(bf[k]),  DW'(m_full[k]));
            check_val($sformatf("err%0d", k),    DW'(er[k]),  DW'(m_e[k]));
        end
    endtask

    task automatic step(input bit we, input int addr, input logic [DW-1:0] d,
                        input bit cm, input bit st);
        wr_en = we; wr_addr = AW'(addr); wr_data = d; wr_commit = cm; start = st;
        @(posedge clk);
        model_edge(0, 1'b0);
        model_edge(1, 1'b1);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, 0, 0);
    endtask

    function automatic logic [DW-1:0] pat(input int k);
        logic [W-1:0] e;
        e = W'(k);
        return {J{e}};
    endfunction

    function automatic logic [DW-1:0] rnd();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic async_reset();
        wr_en = 0; wr_commit = 0; start = 0;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 0; wr_addr = '0; wr_data = '0; wr_commit = 0; start = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;

        // single frame from bank 0
        for (int k = 0; k < I; k++) step(1, k, pat(k), 0, 0);
        step(0, 0, '0, 1, 0);
        step(0, 0, '0, 0, 1);
        idle(10);

        // start with nothing committed
        step(0, 0, '0, 0, 1);
        idle(2);

        // fill both banks, then rejected commit and write
        for (int k = 0; k < I; k++) step(1, k, pat(k + 10), 0, 0);
        step(0, 0, '0, 1, 0);
        for (int k = 0; k < I; k++) step(1, k, pat(k + 20), 0, 0);
        step(0, 0, '0, 1, 0);
        step(0, 0, '0, 1, 0);
        step(1, 3, pat(99), 0, 0);
        idle(1);
        step(0, 0, '0, 0, 1);
        idle(18);
        step(0, 0, '0, 0, 1);
        idle(10);

        // async reset in the middle of a frame
        for (int k = 0; k < I; k++) step(1, k, pat(k + 30), 0, 0);
        step(0, 0, '0, 1, 0);
        step(0, 0, '0, 0, 1);
        idle(2);
        async_reset();
        step(0, 0, '0, 0, 1);
        idle(2);

        // stream bank 0 while filling and committing bank 1
        for (int k = 0; k < I; k++) step(1, k, pat(k + 50), 0, 0);
        step(0, 0, '0, 1, 0);
        step(0, 0, '0, 0, 1);
        for (int k = 0; k < I; k++) step(1, k, pat(k + 60), 0, 0);
        step(1, 7, pat(77), 1, 0);
        idle(3);
        step(0, 0, '0, 0, 1);
        idle(10);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if (($urandom % 500) == 0) begin
                async_reset();
            end else begin
                step(($urandom % 3) == 0, int'($urandom_range(0, 7)), rnd(),
                     ($urandom % 12) == 0, ($urandom % 8) == 0);
            end
        end
        idle(20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
